serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder. It sequences operand bits LSB-first through a single instance of the team's existing full_adder cell, using a registered carry.
- It sits directly upstream of full_adder: it drives full_adder's a/b/cin and consumes its sum/carry.
- Trades latency for area in arithmetic datapaths.
- Start/done handshake toward the controlling logic.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request to begin an addition; accepted only in IDLE
a  input  WIDTH  operand A, captured on the accepting edge
b  input  WIDTH  operand B, captured on the accepting edge
cin  input  1  carry-in, captured on the accepting edge
busy  output  1  high while an addition is in progress (states SHIFT and DONE)
done  output  1  single-cycle pulse: sum/cout valid
sum  output  WIDTH  result; held stable from done until the next accepted start
cout  output  1  final carry-out; held with sum

Behaviour:
- One clock; reset is synchronous and active-low: rst_n low at a rising clk edge forces reset state; no asynchronous path.
- Reset values:
  - state=IDLE, busy=0, done=0, sum=0, cout=0
  - internal shift registers, carry flip-flop and bit counter all 0
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0 loads A_sh<=a, B_sh<=b, carry<=cin, cnt<=0; go to SHIFT.
  - a/b/cin are ignored afterwards.
- SHIFT:
  - full_adder inputs are A_sh[0], B_sh[0], carry.
  - Each edge: A_sh and B_sh shift right by 1, carry<=full_adder carry, sum_sh shifts right with full_adder sum entering at bit WIDTH-1, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th shift edge): copy sum_sh result into sum, carry-out into cout; go to DONE.
- DONE:
  - done=1 for exactly one cycle, then unconditional transition to IDLE.
- Latency:
  - Accept edge E0, shift edges E1..E_WIDTH.
  - done high in the cycle following E_WIDTH, i.e. WIDTH+1 cycles after the accept edge.
  - busy rises after E0 and falls after E_{WIDTH+1}.
- Throughput:
  - Next start is accepted at E_{WIDTH+2} at the earliest (IDLE sampled).
  - Back-to-back starts therefore give one result per WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored and not queued.
  - Operands of the in-flight operation are unaffected.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- sum/cout outputs are registered and change only on the transition into DONE.
  - Intermediate partial sums are never visible on sum.
- Reset mid-operation (rst_n low during SHIFT or DONE):
  - Abandon the operation and return to reset values.
  - No done pulse is issued for the aborted operation.
- start held high continuously: a new operation is accepted at every IDLE visit (every WIDTH+2 cycles).
- The cnt width is clog2(WIDTH) bits.
  - cnt must not wrap before the DONE transition for any legal WIDTH.

Test Plan:
- Reset hold: rst_n=0 for 3 cycles with start=1, a=8'hFF -> busy=0, done=0, sum=8'h00, cout=0 throughout; no operation accepted.
- Basic add, WIDTH=8: a=8'h35, b=8'h4A, cin=0, start pulsed 1 cycle -> done pulses once exactly 9 cycles after the accept edge, sum=8'h7F, cout=0; busy high for 9 cycles.
- Full carry ripple: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1; also a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start while busy:
  - a=8'h10, b=8'h01, cin=0 accepted.
  - 3 cycles later, start=1 with a=8'hAA -> ignored.
  - Result sum=8'h11, cout=0, one done pulse only; sum holds 8'h11 until the next accepted start.
- Reset mid-operation: accept a=8'h80, b=8'h80; assert rst_n=0 for 1 cycle at the 4th shift edge -> no done, sum=8'h00, cout=0, busy=0; a new start then yields correct 8'h00/cout=1.
- Exhaustive check: WIDTH=4, all 512 {a,b,cin} combos with start held high -> every done pulse matches a+b+cin, done spacing exactly 6 cycles.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell and a registered carry, LSB first.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; one result every WIDTH+2 cycles.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, never queued.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_cout;
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                // Last bit: publish the completed shift word so partial sums never reach the output.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {fa_sum, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the named scenarios and a
// 4-bit instance swept over every {a,b,cin} with start held high.

module tb_serial_adder;
    logic       clk;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation on dut8 and watch 20 cycles from the accepting edge.
    task automatic do_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic [7:0] es, input logic ec, input string tag);
        int busy_cnt, done_cnt, done_at;
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        step();
        start8 = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int k = 0; k < 20; k++) begin
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                done_at = k;
            end
            step();
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_at"}, done_at, 8);
        check({tag, "_busy_cycles"}, busy_cnt, 9);
        check({tag, "_sum"}, {24'd0, sum8}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, cout8}, {31'd0, ec});
    endtask

    initial begin
        int done_cnt, seen, last_cyc, bound;
        logic [4:0] exp5;
        rst_n = 1'b0;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;

        // Reset hold with start asserted: nothing may be accepted.
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_busy", {31'd0, busy8}, 0);
            check("rst_done", {31'd0, done8}, 0);
            check("rst_sum", {24'd0, sum8}, 0);
            check("rst_cout", {31'd0, cout8}, 0);
        end
        start8 = 1'b0;
        rst_n = 1'b1;
        step();
        check("idle_after_rst", {31'd0, busy8}, 0);

        do_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "basic");
        do_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "ripple1");
        do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ripple2");
        do_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        do_add(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "alt");

        // Start while busy: second request is dropped.
        a8 = 8'h10; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) begin
                a8 = 8'hAA; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (done8) done_cnt++;
            step();
        end
        check("busy_start_done_cnt", done_cnt, 1);
        check("busy_start_sum", {24'd0, sum8}, 32'h11);
        check("busy_start_cout", {31'd0, cout8}, 0);
        for (int k = 0; k < 5; k++) step();
        check("sum_hold", {24'd0, sum8}, 32'h11);

        // Reset during SHIFT, landing on the 4th shift edge.
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        check("pre_abort_busy", {31'd0, busy8}, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy8}, 0);
        check("abort_sum", {24'd0, sum8}, 0);
        check("abort_cout", {31'd0, cout8}, 0);
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8) done_cnt++;
            step();
        end
        check("abort_no_done", done_cnt, 0);
        do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "after_abort");

        // Exhaustive 4-bit sweep with start held high.
        start4 = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 512; i++) begin
            bound = 0;
            while (busy4 && bound < 10) begin
                step();
                bound++;
            end
            if (busy4) check("sweep_idle_timeout", {31'd0, busy4}, 0);
            a4 = i[8:5]; b4 = i[4:1]; cin4 = i[0];
            exp5 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
            bound = 0; seen = 0;
            while (!seen && bound < 12) begin
                step();
                bound++;
                if (done4) seen = 1;
            end
            check("sweep_done_seen", seen, 1);
            check("sweep_result", {27'd0, cout4, sum4}, {27'd0, exp5});
            if (i > 0) check("sweep_spacing", cyc - last_cyc, 6);
            last_cyc = cyc;
        end
        start4 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
